// File: rtl/delay_line_sequencer.sv
// Sequencer around the fixed-latency delay datapath: issues samples under credit control,
// tracks them with a tag pipeline, and buffers the delayed results with frame markers in a FWFT FIFO.
module delay_line_sequencer #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned LAT         = 20,
    parameter int unsigned N           = 4,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned FCNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_LENGTH-1:0] in_data,
    input  logic                   flush,
    output logic [DATA_LENGTH-1:0] pipe_din,
    input  logic [DATA_LENGTH-1:0] pipe_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LENGTH-1:0] out_data,
    output logic                   out_first,
    output logic                   out_last,
    output logic [FCNT_W-1:0]      frame_cnt,
    output logic                   busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    typedef struct packed {
        logic [DATA_LENGTH-1:0] data;
        logic                   first;
        logic                   last;
    } entry_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    tag_t               tag_q [LAT];
    tag_t               tag_d [LAT];
    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic               issue;
    logic               pop;
    logic               wr_en;
    logic               drained;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign drained   = (credits_q == CNT_W'(DEPTH));
    assign in_ready  = (state_q != FLUSH) && (credits_q != '0);
    assign issue     = in_valid && in_ready;
    assign pipe_din  = issue ? in_data : '0;

    // Head fields are masked while empty so nothing stale leaks out after reset.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head.data : '0;
    assign out_first = out_valid && head.first;
    assign out_last  = out_valid && head.last;
    assign frame_cnt = frame_cnt_q;
    assign busy      = !drained;
    assign wr_en     = tag_q[LAT-1].valid;

    always_comb begin
        state_d     = state_q;
        credits_d   = credits_q;
        count_d     = count_q;
        row_d       = row_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_cnt_d = frame_cnt_q;

        tag_d[0] = '{valid: issue, first: (row_q == '0), last: (row_q == ROW_W'(N - 1))};
        for (int unsigned i = 1; i < LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (issue) begin
            row_d = (row_q == ROW_W'(N - 1)) ? '0 : row_q + ROW_W'(1);
        end

        // Credits mirror free FIFO slots, counting samples still inside the delay line.
        case ({issue, pop})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (head.last) begin
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end
        end

        unique case (state_q)
            IDLE:    if (issue) state_d = RUN;
            RUN:     if (flush) state_d = FLUSH;
            FLUSH: begin
                if (drained) begin
                    state_d = IDLE;
                    row_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            credits_q   <= CNT_W'(DEPTH);
            count_q     <= '0;
            row_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            count_q     <= count_d;
            row_q       <= row_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{data: pipe_dout, first: tag_q[LAT-1].first, last: tag_q[LAT-1].last};
        end
    end

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Bench for delay_line_sequencer: queue-based reference model checked every cycle,
// a vector table for streaming, and directed backpressure / flush / reset sequences.
module tb_delay_line_sequencer;

    localparam int unsigned DW    = 8;
    localparam int unsigned LAT   = 20;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned FW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic [DW-1:0] pipe_din;
    logic [DW-1:0] pipe_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic [FW-1:0] frame_cnt;
    logic          busy;

    always #5 clk = ~clk;

    delay_line_sequencer #(
        .DATA_LENGTH(DW), .LAT(LAT), .N(N), .DEPTH(DEPTH), .FCNT_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .pipe_din(pipe_din), .pipe_dout(pipe_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .frame_cnt(frame_cnt), .busy(busy)
    );

    // Stand-in for the unreset, unstallable delay datapath (LAT register stages).
    logic [DW-1:0] dly_q [LAT];
    always @(posedge clk) begin
        dly_q[0] <= pipe_din;
        for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
    assign pipe_dout = dly_q[LAT-1];

    typedef struct {
        logic [DW-1:0] data;
        bit            first;
        bit            last;
    } item_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            first;
        bit            last;
        int            due;
    } fly_t;

    typedef struct {
        logic [DW-1:0] din;
        bit            exp_first;
        bit            exp_last;
    } vec_t;

    fly_t          inflight[$];
    item_t         fifo_m[$];
    item_t         popped[$];
    logic [DW-1:0] accepted[$];
    int            m_credits, m_row, m_frames, edge_no;
    bit            m_active, m_draining;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        fifo_m.delete();
        m_credits  = DEPTH;
        m_row      = 0;
        m_frames   = 0;
        m_active   = 0;
        m_draining = 0;
    endtask

    // One clock: compare against the model on the falling edge, advance the model, return at posedge+1.
    task automatic tick();
        bit   exp_ready, issue, pop;
        int   old_cr;
        fly_t f;
        item_t it;
        @(negedge clk);
        if (rst_n) begin
            exp_ready = !m_draining && (m_credits != 0);
            issue     = in_valid && exp_ready;
            pop       = (fifo_m.size() != 0) && out_ready;
            check("in_ready", in_ready, exp_ready);
            check("busy", busy, m_credits != DEPTH);
            check("out_valid", out_valid, fifo_m.size() != 0);
            check("frame_cnt", frame_cnt, m_frames % 65536);
            check("pipe_din", pipe_din, issue ? in_data : 8'h00);
            if (fifo_m.size() != 0)
                check("head", {out_data, out_first, out_last},
                      {fifo_m[0].data, fifo_m[0].first, fifo_m[0].last});

            old_cr = m_credits;
            if (pop) begin
                popped.push_back(fifo_m[0]);
                if (fifo_m[0].last) m_frames++;
                void'(fifo_m.pop_front());
            end
            while (inflight.size() != 0 && inflight[0].due == edge_no) begin
                it.data  = inflight[0].data;
                it.first = inflight[0].first;
                it.last  = inflight[0].last;
                fifo_m.push_back(it);
                void'(inflight.pop_front());
            end
            if (issue) begin
                f.data  = in_data;
                f.first = (m_row == 0);
                f.last  = (m_row == N - 1);
                f.due   = edge_no + LAT;
                inflight.push_back(f);
                accepted.push_back(in_data);
                m_row = (m_row + 1) % N;
            end
            m_credits = m_credits - int'(issue) + int'(pop);
            if (m_draining) begin
                if (old_cr == DEPTH) begin
                    m_draining = 0;
                    m_active   = 0;
                    m_row      = 0;
                end
            end else if (m_active) begin
                if (flush) m_draining = 1;
            end else if (issue) begin
                m_active = 1;
            end
        end
        edge_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_first", out_first, 0);
        check("rst out_last", out_last, 0);
        check("rst out_data", out_data, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 1);
        check("rst pipe_din", pipe_din, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        int fc_before;
        int acc0;

        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        edge_no = 0;
        accepted.delete();
        popped.delete();
        #2;
        do_reset();

        // Single sample, first/last flags and exact latency.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check("single early", out_valid, 0);
        tick();
        check("single valid", out_valid, 1);
        check("single data", out_data, 8'h5A);
        check("single first", out_first, 1);
        check("single last", out_last, 0);
        tick();
        check("single busy", busy, 0);

        // Mid-stream reset with samples both buffered and in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            in_data = 8'(8'h30 + i);
            tick();
        end
        do_reset();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT + 5) tick();

        // Streaming vector table.
        vecs[0] = '{8'h01, 1'b1, 1'b0};
        vecs[1] = '{8'h02, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h04, 1'b0, 1'b1};
        vecs[4] = '{8'h05, 1'b1, 1'b0};
        vecs[5] = '{8'h06, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b0, 1'b0};
        vecs[7] = '{8'h08, 1'b0, 1'b1};
        popped.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            check("stream in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 60 && popped.size() < 8; i++) tick();
        check("stream count", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            check("stream vec", {popped[i].data, popped[i].first, popped[i].last},
                  {vecs[i].din, vecs[i].exp_first, vecs[i].exp_last});
        check("stream frame_cnt", frame_cnt, 2);

        // Backpressure: exactly DEPTH accepted, then one per pop.
        popped.delete(); accepted.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'(8'h80 + i);
            tick();
        end
        check("bp accepted", accepted.size(), DEPTH);
        check("bp in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hB0 + i);
            tick();
        end
        check("bp one more", accepted.size(), DEPTH + 1);

        // Pop and issue together leave credits unchanged.
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'hD0;
        check("simul ready before", in_ready, 1);
        tick();
        check("simul ready after", in_ready, 1);
        out_ready = 1'b0; in_data = 8'hD1;
        tick();
        check("simul ready exhausted", in_ready, 0);
        check("simul accepted", accepted.size(), DEPTH + 3);

        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 120 && busy; i++) tick();
        check("bp drain busy", busy, 0);
        check("bp no loss", popped.size(), accepted.size());
        for (int i = 0; i < popped.size() && i < accepted.size(); i++)
            check("bp order", popped[i].data, accepted[i]);

        // Realign with an empty flush, then flush a two-row partial frame.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        fc_before = m_frames;
        popped.delete();
        acc0 = accepted.size();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
        tick();
        in_data = 8'hC2; flush = 1'b1;
        tick();
        flush = 1'b0; in_data = 8'hC3;
        for (int i = 0; i < 30; i++) begin
            check("flush in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && accepted.size() < acc0 + 3; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && popped.size() < 3; i++) tick();
        check("flush count", popped.size(), 3);
        if (popped.size() >= 3) begin
            check("flush row0", {popped[0].data, popped[0].first, popped[0].last}, {8'hC1, 1'b1, 1'b0});
            check("flush row1", {popped[1].data, popped[1].first, popped[1].last}, {8'hC2, 1'b0, 1'b0});
            check("flush next", {popped[2].data, popped[2].first, popped[2].last}, {8'hC3, 1'b1, 1'b0});
        end
        check("flush frame_cnt", frame_cnt, 16'(fc_before));

        // Randomized traffic against the model, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 50) == 0;
            if (i == 1500) do_reset();
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (LAT + DEPTH + 10) tick();
        check("final busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
